// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   Memory-mapped bank of CHANNELS independent WIDTH-bit up-counters. Each
//   channel has a compare target, one-shot or periodic mode, and a
//   write-1-to-clear match flag. The flag can be masked onto the shared irq
//   line. The bank sits on the CPU data bus next to dmem.
//
//   Register map (word address: addr[ADDR_W-1:2] = channel, addr[1:0] = reg)
//     channel c < CHANNELS:
//       0 CTRL   [0]=EN  [1]=AUTO (1 periodic / 0 one-shot)  [2]=IE
//       1 COUNT  running counter (RW)
//       2 TARGET compare value (RW)
//       3 STATUS [0]=FLAG, write 1 to clear
//     channel == CHANNELS (global page):
//       0 PRESC  prescale compare (only with TIMER_BANK_PRESCALE_EN)
//     any other address reads 0 and ignores writes.
//
//   Build option: define TIMER_BANK_PRESCALE_EN to add the shared prescaler.
//   Without it every clock cycle is a tick.
//
// Ports
//   clk    clock
//   rst    asynchronous active-high reset
//   sel    bus select; no write side effects when low
//   we     write strobe, qualified by sel
//   addr   word address
//   wdata  write data
//   rdata  combinational read data for addr
//   irq    OR over channels of (FLAG & IE), from registered state only
// -----------------------------------------------------------------------------
module timer_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              irq
);

  localparam int CH_W = ADDR_W - 2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_TARGET = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [CH_W-1:0] chan;
  logic [1:0]      reg_idx;
  logic            wr_en;
  logic            tick;

  assign chan    = addr[ADDR_W-1:2];
  assign reg_idx = addr[1:0];
  assign wr_en   = sel & we;

  // Per-channel readback values, collected for the read mux.
  logic [WIDTH-1:0]    ctrl_rd   [CHANNELS];
  logic [WIDTH-1:0]    count_rd  [CHANNELS];
  logic [WIDTH-1:0]    target_rd [CHANNELS];
  logic [WIDTH-1:0]    status_rd [CHANNELS];
  logic [CHANNELS-1:0] irq_src;

`ifdef TIMER_BANK_PRESCALE_EN
  logic [WIDTH-1:0] presc_reg;
  logic [WIDTH-1:0] p_reg;
  logic             presc_wr;

  assign presc_wr = wr_en && (chan == CH_W'(CHANNELS)) && (reg_idx == REG_CTRL);
  // One tick every PRESC+1 cycles; PRESC=0 ticks every cycle.
  assign tick     = (p_reg == presc_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      p_reg     <= '0;
    end else begin
      if (presc_wr) begin
        presc_reg <= wdata;
      end
      // Writing PRESC restarts the prescale period so the new ratio is exact.
      if (presc_wr || tick) begin
        p_reg <= '0;
      end else begin
        p_reg <= p_reg + 1'b1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic             ch_wr;
      logic             match;
      logic             en_reg, auto_reg, ie_reg, flag_reg;
      logic [WIDTH-1:0] count_reg, target_reg;
      logic             en_next, flag_next;
      logic [WIDTH-1:0] count_next;

      assign ch_wr = wr_en && (chan == CH_W'(gi));
      // Match always looks at the pre-edge COUNT, even if software
      // overwrites COUNT on the same edge.
      assign match = en_reg & tick & (count_reg == target_reg);

      always_comb begin
        count_next = count_reg;
        en_next    = en_reg;
        flag_next  = flag_reg;

        if (match) begin
          count_next = auto_reg ? '0 : count_reg;
          if (!auto_reg) begin
            en_next = 1'b0;
          end
        end else if (en_reg && tick) begin
          count_next = count_reg + 1'b1;
        end

        // Software writes take priority over the counter's own update.
        if (ch_wr && reg_idx == REG_COUNT) begin
          count_next = wdata;
        end
        if (ch_wr && reg_idx == REG_CTRL) begin
          en_next = wdata[0];
        end

        // A new match wins over a coincident write-1-to-clear.
        if (match) begin
          flag_next = 1'b1;
        end else if (ch_wr && reg_idx == REG_STATUS && wdata[0]) begin
          flag_next = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en_reg     <= 1'b0;
          auto_reg   <= 1'b0;
          ie_reg     <= 1'b0;
          flag_reg   <= 1'b0;
          count_reg  <= '0;
          target_reg <= '0;
        end else begin
          en_reg    <= en_next;
          flag_reg  <= flag_next;
          count_reg <= count_next;
          if (ch_wr && reg_idx == REG_CTRL) begin
            auto_reg <= wdata[1];
            ie_reg   <= wdata[2];
          end
          if (ch_wr && reg_idx == REG_TARGET) begin
            target_reg <= wdata;
          end
        end
      end

      assign ctrl_rd[gi]   = {{(WIDTH-3){1'b0}}, ie_reg, auto_reg, en_reg};
      assign count_rd[gi]  = count_reg;
      assign target_rd[gi] = target_reg;
      assign status_rd[gi] = {{(WIDTH-1){1'b0}}, flag_reg};
      assign irq_src[gi]   = flag_reg & ie_reg;
    end
  endgenerate

  assign irq = |irq_src;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan == CH_W'(c)) begin
        case (reg_idx)
          REG_CTRL:   rdata = ctrl_rd[c];
          REG_COUNT:  rdata = count_rd[c];
          REG_TARGET: rdata = target_rd[c];
          default:    rdata = status_rd[c];
        endcase
      end
    end
`ifdef TIMER_BANK_PRESCALE_EN
    if (chan == CH_W'(CHANNELS) && reg_idx == REG_CTRL) begin
      rdata = presc_reg;
    end
`endif
  end

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//   Directed test of timer_bank built with WIDTH=8, CHANNELS=4, ADDR_W=5.
//   Inputs are driven right after a rising edge; outputs are read 1 ns later
//   so nothing is sampled on the active edge.
// -----------------------------------------------------------------------------
module tb_timer_bank;

  localparam int CTRL   = 0;
  localparam int COUNT  = 1;
  localparam int TARGET = 2;
  localparam int STATUS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       we;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;
  logic [7:0] d;

  int total = 0;
  int bad   = 0;

  timer_bank #(.WIDTH(8), .CHANNELS(4), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  // Single bus write; returns 1 ns after the edge that performs it.
  task automatic wr(input int c, input int r, input logic [7:0] v);
    sel = 1'b1; we = 1'b1; addr = 5'(c * 4 + r); wdata = v;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
    $display("wr ch=%0d reg=%0d data=%02h", c, r, v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic peek(input int c, input int r, output logic [7:0] v);
    addr = 5'(c * 4 + r);
    #1;
    v = rdata;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        peek(c, r, d); total++;
        if (d !== 8'h00) begin bad++; $display("FAIL reset_reg ch%0d r%0d: got %02h want 00", c, r, d); end
      end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_one_shot;
    wr(0, TARGET, 8'd5);
    wr(0, CTRL, 8'b101);
    peek(0, COUNT, d); total++;
    if (d !== 8'd0) begin bad++; $display("FAIL oneshot_start: got %0d want 0", d); end
    for (int k = 1; k <= 5; k++) begin
      step(1);
      peek(0, COUNT, d); total++;
      if (d !== 8'(k)) begin bad++; $display("FAIL oneshot_count k=%0d: got %0d want %0d", k, d, k); end
      peek(0, STATUS, d); total++;
      if (d !== 8'h00) begin bad++; $display("FAIL oneshot_early_flag k=%0d: got %02h want 00", k, d); end
    end
    step(1);
    peek(0, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL oneshot_flag: got %02h want 01", d); end
    peek(0, CTRL, d); total++;
    if (d !== 8'h04) begin bad++; $display("FAIL oneshot_en_clear: got %02h want 04", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    step(2);
    peek(0, COUNT, d); total++;
    if (d !== 8'd5) begin bad++; $display("FAIL oneshot_hold: got %0d want 5", d); end
    wr(0, STATUS, 8'h01);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_periodic;
    wr(2, TARGET, 8'd3);
    wr(2, CTRL, 8'b011);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      peek(2, COUNT, d); total++;
      if (d !== 8'(k % 4)) begin bad++; $display("FAIL periodic_count k=%0d: got %0d want %0d", k, d, k % 4); end
    end
    peek(2, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL periodic_flag1: got %02h want 01", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL periodic_irq_masked: got %b want 0", irq); end
    wr(2, STATUS, 8'h01);
    peek(2, STATUS, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL periodic_w1c: got %02h want 00", d); end
    peek(2, COUNT, d); total++;
    if (d !== 8'd1) begin bad++; $display("FAIL periodic_count5: got %0d want 1", d); end
    step(3);
    peek(2, COUNT, d); total++;
    if (d !== 8'd0) begin bad++; $display("FAIL periodic_reload: got %0d want 0", d); end
    peek(2, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL periodic_flag2: got %02h want 01", d); end
    wr(2, CTRL, 8'h00);
    wr(2, STATUS, 8'h01);
  endtask

  task automatic test_w1c_collision;
    wr(1, TARGET, 8'd2);
    wr(1, CTRL, 8'b101);
    step(2);
    peek(1, COUNT, d); total++;
    if (d !== 8'd2) begin bad++; $display("FAIL w1c_pre_count: got %0d want 2", d); end
    wr(1, STATUS, 8'h01);
    peek(1, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL w1c_set_wins: got %02h want 01", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_set: got %b want 1", irq); end
    wr(1, STATUS, 8'h01);
    peek(1, STATUS, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL w1c_clear: got %02h want 00", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_cnt [3];
    exp_cnt[0] = 8'hFF; exp_cnt[1] = 8'h00; exp_cnt[2] = 8'h01;
    wr(3, COUNT, 8'hFE);
    wr(3, TARGET, 8'h01);
    wr(3, CTRL, 8'b001);
    for (int k = 0; k < 3; k++) begin
      step(1);
      peek(3, COUNT, d); total++;
      if (d !== exp_cnt[k]) begin bad++; $display("FAIL wrap_count k=%0d: got %02h want %02h", k, d, exp_cnt[k]); end
      peek(3, STATUS, d); total++;
      if (d !== 8'h00) begin bad++; $display("FAIL wrap_no_flag k=%0d: got %02h want 00", k, d); end
    end
    // Software COUNT write lands on the match edge.
    wr(3, COUNT, 8'h40);
    peek(3, COUNT, d); total++;
    if (d !== 8'h40) begin bad++; $display("FAIL wrap_count_write_wins: got %02h want 40", d); end
    peek(3, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL wrap_match_flag: got %02h want 01", d); end
    peek(3, CTRL, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL wrap_en_clear: got %02h want 00", d); end
    // TARGET=0 / COUNT=0 matches on the first tick; a CTRL write on that
    // edge beats the one-shot EN clear.
    wr(3, STATUS, 8'h01);
    wr(3, COUNT, 8'h00);
    wr(3, TARGET, 8'h00);
    wr(3, CTRL, 8'b001);
    wr(3, CTRL, 8'b011);
    peek(3, CTRL, d); total++;
    if (d !== 8'h03) begin bad++; $display("FAIL ctrl_write_wins: got %02h want 03", d); end
    peek(3, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL target0_match: got %02h want 01", d); end
    peek(3, COUNT, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL target0_count: got %02h want 00", d); end
    wr(3, CTRL, 8'h00);
    wr(3, STATUS, 8'h01);
    peek(3, STATUS, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL wrap_final_clear: got %02h want 00", d); end
  endtask

  task automatic test_global;
    // Write with sel low must not change TARGET0 (still 5).
    sel = 1'b0; we = 1'b1; addr = 5'(0 * 4 + TARGET); wdata = 8'h99;
    @(posedge clk); #1;
    we = 1'b0;
    peek(0, TARGET, d); total++;
    if (d !== 8'd5) begin bad++; $display("FAIL sel_low_ignored: got %02h want 05", d); end
    wr(5, 1, 8'h33);
    peek(5, 1, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL unmapped_read: got %02h want 00", d); end
    peek(7, 3, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL unmapped_read2: got %02h want 00", d); end
`ifdef TIMER_BANK_PRESCALE_EN
    wr(0, COUNT, 8'h00);
    wr(0, TARGET, 8'h01);
    wr(4, 0, 8'h02);
    peek(4, 0, d); total++;
    if (d !== 8'h02) begin bad++; $display("FAIL presc_readback: got %02h want 02", d); end
    wr(0, CTRL, 8'b001);
    step(4);
    peek(0, COUNT, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL presc_count: got %02h want 01", d); end
    peek(0, STATUS, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL presc_early_flag: got %02h want 00", d); end
    step(1);
    peek(0, STATUS, d); total++;
    if (d !== 8'h01) begin bad++; $display("FAIL presc_match: got %02h want 01", d); end
    wr(4, 0, 8'h00);
    wr(0, STATUS, 8'h01);
`else
    wr(4, 0, 8'h55);
    peek(4, 0, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL global_no_presc: got %02h want 00", d); end
`endif
  endtask

  task automatic test_reset_mid;
    wr(0, COUNT, 8'h00);
    wr(0, TARGET, 8'h02);
    wr(0, STATUS, 8'h01);
    wr(0, CTRL, 8'b101);
    wr(2, TARGET, 8'h77);
    step(2);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_before: got %b want 1", irq); end
    #4 rst = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq_async: got %b want 0", irq); end
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++) begin
        peek(c, r, d); total++;
        if (d !== 8'h00) begin bad++; $display("FAIL mid_reset_reg ch%0d r%0d: got %02h want 00", c, r, d); end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step(2);
    peek(0, COUNT, d); total++;
    if (d !== 8'h00) begin bad++; $display("FAIL post_reset_idle: got %02h want 00", d); end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    step(1);
    test_reset;
    test_one_shot;
    test_periodic;
    test_w1c_collision;
    test_wrap;
    test_global;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
